// File: rtl/sample_feeder.sv
// Paces a sample FIFO into a serial filter: one din/val_in strobe every Num_coef cycles at most.
// Empty-FIFO write reaches din one edge later; s_ready drops only when the FIFO is full.
module sample_feeder #(
  parameter int Win      = 16,
  parameter int Num_coef = 17,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [Win-1:0]           s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [Win-1:0]           din,
  output logic                     val_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (Num_coef > 1) ? $clog2(Num_coef) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(Num_coef - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   gcnt, gcnt_nx;
  logic            issue;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [Win-1:0]  mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    case (state)
      IDLE: begin
        if (issue && (Num_coef > 1)) begin
          state_nx = HOLD;
          gcnt_nx  = GAP_LOAD;
        end
      end
      HOLD: begin
        gcnt_nx = gcnt - GW'(1);
        if (gcnt == GW'(1)) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        gcnt_nx  = '0;
      end
    endcase
  end

  // Issue decision uses pre-edge occupancy, so a sample written this edge cannot bypass.
  always_comb begin
    issue   = (state == IDLE) && (level != '0);
    s_ready = (level != FULL_LVL);
    wr_en   = s_valid && s_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      din    <= '0;
      val_in <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      val_in <= issue;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        din    <= mem[rd_ptr];
      end
      case ({wr_en, issue})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (s_valid && !s_ready) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with a din scoreboard checked on every val_in strobe.
module tb_sample_feeder;
  localparam int W  = 16;
  localparam int NC = 17;
  localparam int D  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] din;
  logic         val_in;
  logic [3:0]   level;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_strobe = -1;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_d;

  sample_feeder #(.Win(W), .Num_coef(NC), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .din(din), .val_in(val_in), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every strobe must carry the oldest accepted sample, spaced >= NC cycles.
  always @(negedge clk) begin
    if (rst) begin
      last_strobe = -1;
    end else if (val_in) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: din=0x%0h with nothing queued", din);
      end else begin
        exp_d = sb.pop_front();
        check("sb_din", 32'(din), 32'(exp_d));
      end
      if (last_strobe >= 0) check("strobe_spacing", 32'((cyc - last_strobe) >= NC), 32'd1);
      last_strobe = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int acc10;
    int strobes;
    bit ovf_seen;
    bit beef_seen;
    bit found;

    // Reset values, both while held and just after release
    #2;
    check("rst_held_val_in", 32'(val_in), 32'd0);
    check("rst_held_level", 32'(level), 32'd0);
    check("rst_held_s_ready", 32'(s_ready), 32'd1);
    do_reset();
    check("rst_val_in", 32'(val_in), 32'd0);
    check("rst_din", 32'(din), 32'h0000);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Single sample, one-edge latency
    do_reset();
    s_valid = 1'b1; s_data = 16'h1234; sb.push_back(s_data);
    tick();
    s_valid = 1'b0;
    check("t2_e0_level", 32'(level), 32'd1);
    check("t2_e0_val_in", 32'(val_in), 32'd0);
    tick();
    check("t2_e1_val_in", 32'(val_in), 32'd1);
    check("t2_e1_din", 32'(din), 32'h1234);
    check("t2_e1_level", 32'(level), 32'd0);
    tick();
    check("t2_e2_val_in", 32'(val_in), 32'd0);

    // Three back-to-back samples: strobes at edges 1, 18, 35
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k < 3) begin
        s_valid = 1'b1; s_data = W'(k + 1); sb.push_back(s_data);
      end else begin
        s_valid = 1'b0;
      end
      tick();
      check("t3_val_in", 32'(val_in), 32'((k == 1) || (k == 18) || (k == 35)));
    end
    check("t3_din_hold", 32'(din), 32'h0003);

    // Ten offers honouring s_ready
    do_reset();
    sent = 0; acc10 = -1; ovf_seen = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      if (sent < 10 && s_ready) begin
        s_valid = 1'b1; s_data = W'(16'h0100 + sent); sb.push_back(s_data);
        if (sent == 9) acc10 = k;
        sent++;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      ovf_seen |= ovf;
      if (k == 8) begin
        check("t4_e8_level", 32'(level), 32'd8);
        check("t4_e8_s_ready", 32'(s_ready), 32'd0);
      end
      if (k == 17) check("t4_e17_s_ready", 32'(s_ready), 32'd0);
      if (k == 18) check("t4_e18_s_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b0;
    check("t4_tenth_accept_edge", 32'(acc10), 32'd19);
    check("t4_ovf_never", 32'(ovf_seen), 32'd0);
    check("t4_full_level", 32'(level), 32'd8);

    // Offer while full: dropped, ovf sticky
    s_valid = 1'b1; s_data = 16'hBEEF;
    tick();
    s_valid = 1'b0;
    check("t5_ovf", 32'(ovf), 32'd1);
    check("t5_level", 32'(level), 32'd8);
    beef_seen = 1'b0; found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (val_in && din == 16'hBEEF) beef_seen = 1'b1;
      if (val_in && level == 4'd5) found = 1'b1;
    end
    check("t5_reached_level5_strobe", 32'(found), 32'd1);
    check("t5_beef_absent", 32'(beef_seen), 32'd0);
    check("t5_ovf_sticky", 32'(ovf), 32'd1);

    // Async reset between edges with 5 queued
    #2;
    rst = 1'b1;
    #1;
    check("t6_val_in", 32'(val_in), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    check("t6_din", 32'(din), 32'h0000);
    check("t6_s_ready", 32'(s_ready), 32'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (val_in) strobes++;
    end
    check("t6_no_strobes", 32'(strobes), 32'd0);
    s_valid = 1'b1; s_data = 16'h5A5A; sb.push_back(s_data);
    tick();
    s_valid = 1'b0;
    tick();
    check("t6_post_val_in", 32'(val_in), 32'd1);
    check("t6_post_din", 32'(din), 32'h5A5A);
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter Win, default 16, sample width in bits (matches filter input width).
REQ-002 Parameter Num_coef, default 17, filter coefficient count; sets minimum spacing between issued samples.
REQ-003 Parameter DEPTH, default 8, FIFO depth in samples; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  Win  signed sample from upstream.
REQ-007 s_valid  input  1  upstream sample present on s_data.
REQ-008 s_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 din  output  Win  signed sample to the serial filter, registered.
REQ-010 val_in  output  1  one-cycle strobe qualifying din, registered.
REQ-011 level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-012 ovf  output  1  sticky flag: sample offered while FIFO full.

Function
REQ-013 Write handshake: a sample is stored when s_valid and s_ready are both 1 at a rising edge.
REQ-014 s_ready is combinational, equal to (level != DEPTH); it does not look ahead to a same-cycle read.
REQ-015 FIFO order is strict first-in first-out; pointers wrap modulo DEPTH.
REQ-016 Gap counter gcnt, range 0..Num_coef-1; two states: IDLE (gcnt==0) and HOLD (gcnt>0).
REQ-017 Issue condition at a rising edge: state IDLE and level>0 before that edge.
REQ-018 On issue: din <= FIFO head, val_in <= 1, head popped, gcnt <= Num_coef-1 (enters HOLD).
REQ-019 When not issuing: val_in <= 0; din holds its last value.
REQ-020 In HOLD, gcnt decrements by 1 each edge; at 0 the state is IDLE.
REQ-021 Consecutive val_in strobes are therefore exactly Num_coef cycles apart while FIFO is non-empty, never closer.
REQ-022 Latency: sample written to an empty FIFO at edge t while IDLE appears with val_in=1 after edge t+1.
REQ-023 A sample written at edge t is never issued at edge t (no FIFO bypass).
REQ-024 Same-edge write and issue: level unchanged; both operations take effect.
REQ-025 Write attempt while full (s_valid=1, s_ready=0): sample discarded, FIFO unchanged, ovf <= 1.
REQ-026 ovf stays 1 until reset; no other clear.
REQ-027 Empty FIFO in IDLE: no strobe, state stays IDLE, val_in=0.

Reset
REQ-028 rst=1 forces immediately, independent of clk: val_in=0, din=0, level=0, ovf=0, gcnt=0 (IDLE), pointers=0.
REQ-029 Reset mid-operation discards all queued samples and any pending spacing; s_ready=1 while rst=1.
REQ-030 After rst deasserts, the first edge follows normal REQ-013..REQ-027 rules.

Verification (Win=16, Num_coef=17, DEPTH=8; edge 0 = first write edge)
REQ-031 Reset: pulse rst, no traffic -> val_in=0, din=0x0000, level=0, ovf=0, s_ready=1.
REQ-032 Single sample 0x1234 at edge 0 -> after edge 1: val_in=1, din=0x1234, level=0; val_in=0 after edge 2.
REQ-033 Three back-to-back samples 0x0001,0x0002,0x0003 at edges 0-2 -> strobes after edges 1, 18, 35 carrying 0x0001, 0x0002, 0x0003; din holds 0x0003 afterwards.
REQ-034 Ten consecutive offers from edge 0 -> level=8 and s_ready=0 after edge 8; s_ready=1 after edge 18; tenth sample accepted at edge 19; ovf=0 throughout.
REQ-035 Full FIFO (8 queued, HOLD), force s_valid=1 ignoring s_ready for one edge with 0xBEEF -> ovf=1, level=8, 0xBEEF never appears on din.
REQ-036 Async reset asserted mid-cycle between edges with 5 samples queued -> val_in, level, ovf drop to 0 before next edge; no further strobes until new data is written.
